bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter SATURATE, default 1: 1 = out-of-range result forced to 16'h9999; 0 = low four BCD digits passed through.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port i_valid, input, 1: a conversion request is present.
REQ-005 SHALL have port i_bin, input, 16: unsigned binary value to convert.
REQ-006 SHALL have port o_ready, output, 1: block idle and able to accept a request.
REQ-007 SHALL have port o_valid, output, 1: one-cycle pulse marking a new result on o_bcd.
REQ-008 SHALL have port o_bcd, output, 16: 4-digit packed BCD, MS digit in [15:12], intended to drive ssd_ctrl i_num_bcd directly.
REQ-009 SHALL have port o_ovf, output, 1: last result exceeded 9999.

Function
REQ-010 SHALL implement a 3-state FSM: IDLE, CONV, DONE.
REQ-011 SHALL, in IDLE, drive o_ready=1; in all other states o_ready=0.
REQ-012 SHALL accept a request on an edge where i_valid=1 and o_ready=1.
REQ-013 SHALL, on that accept edge, capture i_bin into the shift register, clear the 20-bit (5-digit) BCD accumulator and iteration counter, and go to CONV.
REQ-014 SHALL ignore i_valid while not in IDLE; such requests are dropped, not queued.
REQ-015 SHALL ignore changes on i_bin after the accept edge.
REQ-016 SHALL perform one double-dabble iteration per CONV cycle.
- Each iteration: every BCD digit >=5 gets +3.
- Then the {accumulator, shift register} pair shifts left by 1.
REQ-017 SHALL leave CONV for DONE after exactly 16 iterations, using a 4-bit counter that wraps 15->0 on the final iteration.
REQ-018 SHALL, on the DONE->IDLE edge, load o_bcd and o_ovf and set o_valid=1 for exactly one cycle.
- Result: o_valid is high in the 17th cycle after the accept edge, and o_ready is high in that same cycle.
REQ-019 SHALL set o_ovf=1 when the 5th (ten-thousands) digit is nonzero, i.e. i_bin>9999; otherwise o_ovf=0.
REQ-020 SHALL, when o_ovf=1, output o_bcd=16'h9999 if SATURATE=1, else the low 4 digits of the accumulator.
REQ-021 SHALL hold o_bcd and o_ovf stable between o_valid pulses, so the display never shows intermediate values.
REQ-022 SHALL accept a new request on the same edge that o_valid is high (back-to-back throughput: one result per 17 cycles).
REQ-023 SHALL produce every digit in range 0-9; no hex digits A-F appear on o_bcd.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, force state=IDLE, o_ready=1, o_valid=0, o_bcd=16'h0000, o_ovf=0, counter=0.
REQ-025 SHALL abort any conversion in progress on reset, with no o_valid pulse for the aborted request.
REQ-026 SHALL give rst priority over a simultaneous i_valid.

Structure
REQ-027 SHALL take the following from shared package bcd_pkg:
- FSM state enum.
- Constants N_ITER=16, N_DIGITS=4, BCD_SAT=16'h9999.
REQ-028 SHALL instantiate combinational sub-module bcd_digit_adj (4-bit in, 4-bit out, +3 when >=5) once per accumulator digit (5 instances).
REQ-029 SHALL register all outputs; no combinational path from inputs to outputs.

Verification
REQ-030 SHALL verify: i_bin=16'd0 accepted -> 17 cycles later o_valid pulse, o_bcd=16'h0000, o_ovf=0.
REQ-031 SHALL verify: i_bin=16'd1234 -> o_bcd=16'h1234, o_ovf=0, o_valid high exactly one cycle; i_bin=16'd9999 -> 16'h9999, o_ovf=0.
REQ-032 SHALL verify: i_bin=16'd10000 with SATURATE=1 -> o_bcd=16'h9999, o_ovf=1; i_bin=16'd65535 with SATURATE=0 -> o_bcd=16'h5535, o_ovf=1.
REQ-033 SHALL verify: i_bin=16'd42 accepted, then i_valid=1 with i_bin=16'd77 at cycle 5 -> no accept (o_ready=0), result 16'h0042, single o_valid.
REQ-034 SHALL verify: rst=1 at cycle 8 of a 16'd5678 conversion -> next cycle o_ready=1, o_bcd=16'h0000, and no o_valid for that request.
REQ-035 SHALL verify: requests 16'd1 then 16'd8765 issued back-to-back (second on the o_valid cycle) -> o_valid pulses 17 cycles apart, values 16'h0001 then 16'h8765.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state type, the iteration/digit constants and the saturation value.
package bcd_pkg;

    localparam int unsigned BIN_W      = 16;
    localparam int unsigned N_ITER     = 16;
    localparam int unsigned N_DIGITS   = 4;
    localparam int unsigned ACC_DIGITS = N_DIGITS + 1;
    localparam int unsigned ACC_W      = 4 * ACC_DIGITS;
    localparam int unsigned BCD_W      = 4 * N_DIGITS;
    localparam int unsigned CNT_W      = 4;

    localparam logic [BCD_W-1:0] BCD_SAT = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
// Ports:
//   digit       - current 4-bit BCD digit
//   digit_adj_c - corrected digit (combinational)
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] digit_adj_c
);

    always_comb begin
        digit_adj_c = digit;
        if (digit >= 4'd5) begin
            digit_adj_c = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (shift-and-add-3).
// One iteration per clock; a result is presented 17 clocks after acceptance.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   i_valid/i_bin - conversion request and the unsigned value to convert
//   o_ready       - idle, a request will be accepted on the next edge
//   o_valid       - one-cycle pulse, new o_bcd/o_ovf value
//   o_bcd         - packed BCD result, MS digit in [15:12]
//   o_ovf         - last value exceeded 9999
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [BIN_W-1:0] i_bin,
    output logic             o_ready,
    output logic             o_valid,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_ovf
);

    state_t                     state, state_nxt;
    logic [BIN_W-1:0]           shift_q, shift_nxt;
    logic [ACC_W-1:0]           acc_q, acc_nxt;
    logic [CNT_W-1:0]           cnt_q, cnt_nxt;
    logic [ACC_W-1:0]           acc_adj;
    logic [ACC_W+BIN_W-1:0]     pair_shl;
    logic                       load_res;
    logic                       ovf_c;
    logic [BCD_W-1:0]           bcd_res;

    // Per-digit +3 correction of the accumulator.
    for (genvar g = 0; g < int'(ACC_DIGITS); g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit       (acc_q[4*g +: 4]),
            .digit_adj_c (acc_adj[4*g +: 4])
        );
    end

    assign pair_shl = {acc_adj, shift_q} << 1;

    // Ten-thousands digit nonzero means the value does not fit in four digits.
    assign ovf_c   = |acc_q[ACC_W-1:BCD_W];
    assign bcd_res = (ovf_c && SATURATE) ? BCD_SAT : acc_q[BCD_W-1:0];

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        acc_nxt   = acc_q;
        cnt_nxt   = cnt_q;
        load_res  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    shift_nxt = i_bin;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_nxt   = pair_shl[ACC_W+BIN_W-1:BIN_W];
                shift_nxt = pair_shl[BIN_W-1:0];
                cnt_nxt   = cnt_q + CNT_W'(1);
                // Counter wraps to zero on the last iteration.
                if (cnt_q == CNT_W'(N_ITER - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                load_res  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_bcd   <= '0;
            o_ovf   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            acc_q   <= acc_nxt;
            cnt_q   <= cnt_nxt;
            o_ready <= (state_nxt == ST_IDLE);
            o_valid <= load_res;
            if (load_res) begin
                o_bcd <= bcd_res;
                o_ovf <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: two instances (saturating and
// pass-through) run in lockstep on the same request stream.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_bin;
    logic        o_ready_s, o_valid_s, o_ovf_s;
    logic [15:0] o_bcd_s;
    logic        o_ready_r, o_valid_r, o_ovf_r;
    logic [15:0] o_bcd_r;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bin2bcd_seq #(.SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_bin(i_bin),
        .o_ready(o_ready_s), .o_valid(o_valid_s), .o_bcd(o_bcd_s), .o_ovf(o_ovf_s)
    );

    bin2bcd_seq #(.SATURATE(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_bin(i_bin),
        .o_ready(o_ready_r), .o_valid(o_valid_r), .o_bcd(o_bcd_r), .o_ovf(o_ovf_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd_sat;
        logic [15:0] bcd_raw;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal reference: digits by division, then the overflow rule.
    function automatic logic [16:0] model(input int v, input bit sat);
        int          d4;
        int          r;
        logic [15:0] b;
        d4 = v / 10000;
        r  = v % 10000;
        b  = {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
        if (d4 != 0 && sat) b = 16'h9999;
        return {d4 != 0, b};
    endfunction

    function automatic logic any_hex(input logic [15:0] b);
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Issue one request, scramble i_bin afterwards, wait for the result and
    // check latency, handshake and hold behaviour. Leaves time at the o_valid cycle.
    task automatic do_conv(input logic [15:0] v, input bit check_pulse,
                           output logic [15:0] bs, output logic os,
                           output logic [15:0] br, output logic ovr);
        int          w;
        int          lat;
        logic [15:0] held;
        bit          moved;
        w = 0;
        while (!o_ready_s && w < 40) begin
            step();
            w++;
        end
        chk("ready_before_req", 32'(o_ready_s), 32'd1);
        held    = o_bcd_s;
        moved   = 1'b0;
        i_valid = 1'b1;
        i_bin   = v;
        step();
        i_valid = 1'b0;
        i_bin   = 16'($urandom);
        lat     = 0;
        while (!o_valid_s && lat < 40) begin
            if (o_bcd_s !== held) moved = 1'b1;
            step();
            lat++;
            i_bin = 16'($urandom);
        end
        chk("latency", 32'(lat), 32'd17);
        chk("bcd_held_while_busy", 32'(moved), 32'd0);
        chk("valid_lockstep", 32'(o_valid_r), 32'd1);
        chk("ready_with_valid", 32'(o_ready_s), 32'd1);
        chk("no_hex_digits", 32'(any_hex(o_bcd_s) | any_hex(o_bcd_r)), 32'd0);
        bs  = o_bcd_s;
        os  = o_ovf_s;
        br  = o_bcd_r;
        ovr = o_ovf_r;
        if (check_pulse) begin
            step();
            chk("valid_one_cycle", 32'(o_valid_s), 32'd0);
            chk("bcd_held_after", 32'(o_bcd_s), 32'(bs));
        end
    endtask

    task automatic no_valid_for(input int n, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (o_valid_s || o_valid_r) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [15:0] bs, br;
        logic        os, ovr;
        logic [16:0] m;
        logic [15:0] v;
        int          lat;

        vecs[0]  = '{16'd0,     16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{16'd1234,  16'h1234, 16'h1234, 1'b0};
        vecs[2]  = '{16'd9999,  16'h9999, 16'h9999, 1'b0};
        vecs[3]  = '{16'd10000, 16'h9999, 16'h0000, 1'b1};
        vecs[4]  = '{16'd65535, 16'h9999, 16'h5535, 1'b1};
        vecs[5]  = '{16'd42,    16'h0042, 16'h0042, 1'b0};
        vecs[6]  = '{16'd5,     16'h0005, 16'h0005, 1'b0};
        vecs[7]  = '{16'd10,    16'h0010, 16'h0010, 1'b0};
        vecs[8]  = '{16'd50000, 16'h9999, 16'h0000, 1'b1};
        vecs[9]  = '{16'd8765,  16'h8765, 16'h8765, 1'b0};
        vecs[10] = '{16'd10001, 16'h9999, 16'h0001, 1'b1};

        rst     = 1'b1;
        i_valid = 1'b0;
        i_bin   = 16'd0;
        step();
        step();
        chk("rst_ready", 32'(o_ready_s), 32'd1);
        chk("rst_valid", 32'(o_valid_s), 32'd0);
        chk("rst_bcd",   32'(o_bcd_s),   32'd0);
        chk("rst_ovf",   32'(o_ovf_s),   32'd0);
        rst = 1'b0;
        step();

        // Directed table.
        foreach (vecs[i]) begin
            do_conv(vecs[i].bin, 1'b1, bs, os, br, ovr);
            chk($sformatf("tbl%0d_bcd_sat", i), 32'(bs),  32'(vecs[i].bcd_sat));
            chk($sformatf("tbl%0d_ovf_sat", i), 32'(os),  32'(vecs[i].ovf));
            chk($sformatf("tbl%0d_bcd_raw", i), 32'(br),  32'(vecs[i].bcd_raw));
            chk($sformatf("tbl%0d_ovf_raw", i), 32'(ovr), 32'(vecs[i].ovf));
        end

        // Random values against the decimal model.
        for (int k = 0; k < 24; k++) begin
            v = (k % 3 == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
            do_conv(v, 1'b1, bs, os, br, ovr);
            m = model(int'(v), 1'b1);
            chk($sformatf("rnd_%0d_sat", v), 32'({os, bs}), 32'(m));
            m = model(int'(v), 1'b0);
            chk($sformatf("rnd_%0d_raw", v), 32'({ovr, br}), 32'(m));
        end

        // Request while busy is dropped.
        i_valid = 1'b1;
        i_bin   = 16'd42;
        step();
        i_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        i_valid = 1'b1;
        i_bin   = 16'd77;
        chk("busy_ready_low", 32'(o_ready_s), 32'd0);
        step();
        i_valid = 1'b0;
        lat = 5;
        while (!o_valid_s && lat < 40) begin
            step();
            lat++;
        end
        chk("busy_latency", 32'(lat), 32'd17);
        chk("busy_bcd", 32'(o_bcd_s), 32'h0042);
        step();
        chk("busy_single_valid", 32'(o_valid_s), 32'd0);
        no_valid_for(25, "busy_no_second_result");

        // Reset mid-conversion aborts without a result.
        i_valid = 1'b1;
        i_bin   = 16'd5678;
        step();
        i_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ready", 32'(o_ready_s), 32'd1);
        chk("abort_bcd",   32'(o_bcd_s),   32'h0000);
        chk("abort_valid", 32'(o_valid_s), 32'd0);
        chk("abort_ovf",   32'(o_ovf_r),   32'd0);
        no_valid_for(25, "abort_no_result");

        // Reset wins over a simultaneous request.
        do_conv(16'd321, 1'b1, bs, os, br, ovr);
        rst     = 1'b1;
        i_valid = 1'b1;
        i_bin   = 16'd123;
        step();
        rst     = 1'b0;
        i_valid = 1'b0;
        chk("rst_prio_ready", 32'(o_ready_s), 32'd1);
        chk("rst_prio_bcd",   32'(o_bcd_s),   32'h0000);
        no_valid_for(25, "rst_prio_no_result");

        // Back-to-back: second request accepted on the o_valid cycle.
        do_conv(16'd1, 1'b0, bs, os, br, ovr);
        chk("b2b_first", 32'(bs), 32'h0001);
        do_conv(16'd8765, 1'b1, bs, os, br, ovr);
        chk("b2b_second", 32'(bs), 32'h8765);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
